predictor_ctrl: RTL and testbench

Shared branch-prediction controller. It owns a pattern-history table (PHT) of 2-bit saturating counters and arbitrates lookups from two requesters (fetch port 0, fetch port 1) round-robin. It tracks up to DEPTH outstanding predictions in order and applies resolved outcomes (result/taken) to the counter that produced each prediction. It sits between the fetch ports and branch resolution and replaces per-port predictor instances with one shared, indexed table.

---
 rtl/predictor_ctrl.sv | 130 +++++++++++++
 tb/tb_predictor_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/predictor_ctrl.sv
// predictor_ctrl
//   Shared branch predictor: a pattern-history table (PHT) of 2-bit saturating
//   counters serving two fetch ports through a round-robin arbiter.
//   Predictions stay in an in-order FIFO until branch resolution. Each resolved
//   outcome then trains the counter that made the prediction.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   req0/pc0, req1/pc1   lookup requests and PHT indices, held until granted
//   grant0/grant1        combinational grants (at most one per cycle)
//   pred_valid/port      registered lookup result, one cycle after the grant
//   prediction           registered predicted direction (1 = taken)
//   result/taken         resolution of the oldest outstanding prediction
//   mispredict           registered pulse: the oldest prediction was wrong
//   resolve_err          registered pulse: result arrived with nothing outstanding
//   full                 combinational; DEPTH predictions outstanding
module predictor_ctrl #(
  parameter int IDX_W = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [IDX_W-1:0] pc0,
  input  logic             req1,
  input  logic [IDX_W-1:0] pc1,
  output logic             grant0,
  output logic             grant1,
  output logic             pred_valid,
  output logic             pred_port,
  output logic             prediction,
  input  logic             result,
  input  logic             taken,
  output logic             mispredict,
  output logic             resolve_err,
  output logic             full
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0]       pht       [ENTRIES];
  logic [IDX_W-1:0] fifo_pc   [DEPTH];
  logic             fifo_pred [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic             last_grant;

  logic             gnt0_p0, gnt1_p0, gnt_p0, pop_p0;
  logic [IDX_W-1:0] lk_pc_p0, head_pc_p0;
  logic             lk_pred_p0, head_pred_p0;

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic tk);
    logic [1:0] n;
    n = c;
    if (tk && c != 2'b11)
      n = c + 2'b01;
    else if (!tk && c != 2'b00)
      n = c - 2'b01;
    return n;
  endfunction

  // ---- stage p0: arbitration, PHT read and FIFO head (combinational) ----
  // The reset gate keeps grants low while rst is asserted, even if requests
  // are held. count is cleared asynchronously, so full is low during reset too.
  assign full    = (count == CNT_W'(DEPTH));
  assign gnt0_p0 = !rst && !full && req0 && (!req1 || last_grant);
  assign gnt1_p0 = !rst && !full && req1 && (!req0 || !last_grant);
  assign gnt_p0  = gnt0_p0 | gnt1_p0;
  assign grant0  = gnt0_p0;
  assign grant1  = gnt1_p0;

  assign lk_pc_p0     = gnt1_p0 ? pc1 : pc0;
  // Read before write: a lookup sees the counter value from before any
  // resolve update in the same cycle.
  assign lk_pred_p0   = pht[lk_pc_p0][1];
  assign head_pc_p0   = fifo_pc[head];
  assign head_pred_p0 = fifo_pred[head];
  assign pop_p0       = result && (count != '0);

  // ---- stage p1: table update, FIFO and registered outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) pht[i] <= 2'b00;
    end else if (pop_p0) begin
      pht[head_pc_p0] <= ctr_next(pht[head_pc_p0], taken);
    end
  end

  always_ff @(posedge clk) begin
    if (gnt_p0) begin
      fifo_pc[tail]   <= lk_pc_p0;
      fifo_pred[tail] <= lk_pred_p0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      last_grant  <= 1'b1;
      pred_valid  <= 1'b0;
      pred_port   <= 1'b0;
      prediction  <= 1'b0;
      mispredict  <= 1'b0;
      resolve_err <= 1'b0;
    end else begin
      if (gnt_p0) begin
        tail       <= tail + 1'b1;
        last_grant <= gnt1_p0;
      end
      if (pop_p0)
        head <= head + 1'b1;
      // A push and a pop in the same cycle leave the occupancy unchanged.
      case ({gnt_p0, pop_p0})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      pred_valid  <= gnt_p0;
      pred_port   <= gnt1_p0;
      prediction  <= gnt_p0 & lk_pred_p0;
      mispredict  <= pop_p0 && (head_pred_p0 != taken);
      resolve_err <= result && (count == '0);
    end
  end

endmodule

// File: tb/tb_predictor_ctrl.sv
module tb_predictor_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, result, taken;
  logic [3:0] pc0, pc1;
  logic       grant0, grant1, pred_valid, pred_port, prediction;
  logic       mispredict, resolve_err, full;

  int n_vec = 0;
  int n_err = 0;

  predictor_ctrl #(.IDX_W(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .pc0(pc0), .req1(req1), .pc1(pc1),
    .grant0(grant0), .grant1(grant1),
    .pred_valid(pred_valid), .pred_port(pred_port), .prediction(prediction),
    .result(result), .taken(taken),
    .mispredict(mispredict), .resolve_err(resolve_err), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, r0;
    logic [3:0] p0;
    logic       r1;
    logic [3:0] p1;
    logic       res, tk;
    logic       g0, g1, fl, pv, pp, pr, mp, re;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rst_i, r0, input logic [3:0] p0,
                              input logic r1, input logic [3:0] p1,
                              input logic res, tk,
                              input logic g0, g1, fl, pv, pp, pr, mp, re);
    vec_t v;
    v.rst = rst_i; v.r0 = r0; v.p0 = p0; v.r1 = r1; v.p1 = p1;
    v.res = res;   v.tk = tk;
    v.g0 = g0; v.g1 = g1; v.fl = fl; v.pv = pv;
    v.pp = pp; v.pr = pr; v.mp = mp; v.re = re;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %b, expected %b", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input vec_t v);
    n_vec++;
    chk("grant0", idx, grant0, v.g0);
    chk("grant1", idx, grant1, v.g1);
    chk("full", idx, full, v.fl);
    chk("pred_valid", idx, pred_valid, v.pv);
    chk("pred_port", idx, pred_port, v.pp);
    chk("prediction", idx, prediction, v.pr);
    chk("mispredict", idx, mispredict, v.mp);
    chk("resolve_err", idx, resolve_err, v.re);
  endtask

  initial begin
    rst = 1'b1; req0 = 0; req1 = 0; pc0 = 0; pc1 = 0; result = 0; taken = 0;

    //            rst r0 p0 r1 p1 res tk   g0 g1 fl pv pp pr mp re
    // reset with requests held, then a single port-0 lookup on pc 3
    vq.push_back(mk(1, 1, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0)); // 0
    vq.push_back(mk(0, 1, 3, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0)); // 1
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 1, 0, 0, 0, 0)); // 2
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0)); // 3
    // both ports held: 0,1,0,1 then full blocks, even while a result pops
    vq.push_back(mk(0, 1, 0, 1, 1, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0)); // 4
    vq.push_back(mk(0, 1, 0, 1, 1, 0, 0,   0, 1, 0, 1, 0, 0, 0, 0)); // 5
    vq.push_back(mk(0, 1, 0, 1, 1, 0, 0,   1, 0, 0, 1, 1, 0, 0, 0)); // 6
    vq.push_back(mk(0, 1, 0, 1, 1, 0, 0,   0, 1, 0, 1, 0, 0, 0, 0)); // 7
    vq.push_back(mk(0, 1, 0, 1, 1, 0, 0,   0, 0, 1, 1, 1, 0, 0, 0)); // 8
    vq.push_back(mk(0, 1, 0, 1, 1, 1, 0,   0, 0, 1, 0, 0, 0, 0, 0)); // 9
    // drain, then a result with nothing outstanding
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0)); // 10
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 0, 0)); // 11
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 1, 0)); // 12
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 1, 0)); // 13
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1)); // 14
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0)); // 15
    // train pc 5: 00->01->10->11, saturate, then 11->10->01
    vq.push_back(mk(0, 1, 5, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0)); // 16
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 1, 0, 0, 0, 0)); // 17
    vq.push_back(mk(0, 1, 5, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1, 0)); // 18
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 1, 0, 0, 0, 0)); // 19
    vq.push_back(mk(0, 1, 5, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1, 0)); // 20
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 1, 0, 1, 0, 0)); // 21
    vq.push_back(mk(0, 1, 5, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0)); // 22
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 1, 0, 1, 0, 0)); // 23
    vq.push_back(mk(0, 1, 5, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0)); // 24
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 1, 0, 1, 0, 0)); // 25
    vq.push_back(mk(0, 1, 5, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1, 0)); // 26
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 1, 0, 1, 0, 0)); // 27
    vq.push_back(mk(0, 1, 5, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1, 0)); // 28
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 1, 0, 0, 0, 0)); // 29
    // pc 2 then pc 7 outstanding, resolved in order; repeat, then read back
    vq.push_back(mk(0, 0, 0, 1, 2, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0)); // 30
    vq.push_back(mk(0, 0, 0, 1, 7, 0, 0,   0, 1, 0, 1, 1, 0, 0, 0)); // 31
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 1, 1, 0, 0, 0)); // 32
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 1, 0)); // 33
    vq.push_back(mk(0, 1, 2, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1, 0)); // 34
    vq.push_back(mk(0, 1, 7, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 0, 0)); // 35
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 1, 0, 0, 0, 0)); // 36
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 1, 0)); // 37
    vq.push_back(mk(0, 1, 2, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1, 0)); // 38
    vq.push_back(mk(0, 1, 7, 0, 0, 0, 0,   1, 0, 0, 1, 0, 1, 0, 0)); // 39
    vq.push_back(mk(0, 1, 3, 0, 0, 0, 0,   1, 0, 0, 1, 0, 1, 0, 0)); // 40
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 1, 0, 0, 0, 0)); // 41
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 1, 0)); // 42
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 1, 0)); // 43
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0)); // 44
    // pc 4 to 01, then grant pc 4 in the same cycle as its taken resolve
    vq.push_back(mk(0, 1, 4, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0)); // 45
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 1, 0, 0, 0, 0)); // 46
    vq.push_back(mk(0, 1, 4, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1, 0)); // 47
    vq.push_back(mk(0, 1, 4, 0, 0, 1, 1,   1, 0, 0, 1, 0, 0, 0, 0)); // 48
    vq.push_back(mk(0, 1, 4, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 1, 0)); // 49
    // fill the FIFO, asynchronous reset, then an orphan result
    vq.push_back(mk(0, 1, 9, 0, 0, 0, 0,   1, 0, 0, 1, 0, 1, 0, 0)); // 50
    vq.push_back(mk(0, 1, 7, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 0, 0)); // 51
    vq.push_back(mk(1, 1, 4, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0)); // 52
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 0, 0)); // 53
    vq.push_back(mk(0, 1, 4, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1)); // 54
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 0)); // 55

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; req0 = vq[i].r0; pc0 = vq[i].p0;
      req1 = vq[i].r1; pc1 = vq[i].p1; result = vq[i].res; taken = vq[i].tk;
      #1 check_all(i, vq[i]);
    end

    // Sweep every index after a reset: each lookup is granted and predicts
    // not-taken, while the previous entry resolves not-taken alongside it.
    @(negedge clk);
    rst = 1'b1; req0 = 0; req1 = 0; result = 0; taken = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vec_t e;
      @(negedge clk);
      req0 = 1'b1; pc0 = 4'(i); result = (i != 0); taken = 1'b0;
      e = mk(0, 1, 4'(i), 0, 0, (i != 0), 0, 1, 0, 0, (i != 0), 0, 0, 0, 0);
      #1 check_all(100 + i, e);
    end
    @(negedge clk);
    req0 = 1'b0; result = 1'b0;
    #1 check_all(116, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
